// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/addr_ok/data_ok bus.
// Optional ID-stage bypass/load-use outputs are built when MEM_FWD_EN is defined.
module mem_stage #(
    parameter int unsigned TO_MEM_W = 104,
    parameter int unsigned TO_WB_W  = 70
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                EX_to_MEM_valid,
    input  logic [TO_MEM_W-1:0] to_MEM_data,
    output logic                MEM_allow_in,
    input  logic                WB_allow_in,
    output logic                MEM_to_WB_valid,
    output logic [TO_WB_W-1:0]  to_WB_data,
    output logic                data_req,
    output logic                data_wr,
    output logic [31:0]         data_addr,
    output logic [3:0]          data_wstrb,
    output logic [31:0]         data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [31:0]         data_rdata
`ifdef MEM_FWD_EN
    ,
    output logic                MEM_fwd_valid,
    output logic [4:0]          MEM_fwd_dest,
    output logic                MEM_fwd_stall
`endif
);

    localparam int unsigned GR_WE_BIT = 0;
    localparam int unsigned DEST_LSB  = 1;
    localparam int unsigned RFM_BIT   = 6;
    localparam int unsigned WE_BIT    = 7;
    localparam int unsigned RKD_LSB   = 8;
    localparam int unsigned ALU_LSB   = 40;
    localparam int unsigned PC_LSB    = 72;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mem_state_t;

    mem_state_t          state;
    mem_state_t          state_nxt;
    logic                MEM_valid;
    logic [TO_MEM_W-1:0] mem_bundle;
    logic [31:0]         rdata_q;
    logic                rdata_cap;

    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] rkd_value;
    logic        mem_we;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic        gr_we;
    logic        is_mem;
    logic        in_is_mem;
    logic        accept;
    logic        MEM_ready_go;
    logic [31:0] final_result;

    // Field views of the held bundle
    assign pc           = mem_bundle[PC_LSB  +: 32];
    assign alu_result   = mem_bundle[ALU_LSB +: 32];
    assign rkd_value    = mem_bundle[RKD_LSB +: 32];
    assign mem_we       = mem_bundle[WE_BIT];
    assign res_from_mem = mem_bundle[RFM_BIT];
    assign dest         = mem_bundle[DEST_LSB +: 5];
    assign gr_we        = mem_bundle[GR_WE_BIT];

    assign is_mem    = mem_we | res_from_mem;
    assign in_is_mem = to_MEM_data[WE_BIT] | to_MEM_data[RFM_BIT];

    // Handshake with the neighbouring stages
    assign MEM_ready_go    = !is_mem || (state == S_DONE);
    assign MEM_allow_in    = !MEM_valid || (MEM_ready_go && WB_allow_in);
    assign MEM_to_WB_valid = MEM_valid && MEM_ready_go;
    assign accept          = EX_to_MEM_valid && MEM_allow_in;

    assign final_result = res_from_mem ? rdata_q : alu_result;
    assign to_WB_data   = {pc, final_result, dest, gr_we};

    // Bus request fields come straight from the held bundle, so they stay stable in REQ
    assign data_req   = (state == S_REQ);
    assign data_wr    = mem_we;
    assign data_addr  = {alu_result[31:2], 2'b00};
    assign data_wstrb = mem_we ? 4'hf : 4'h0;
    assign data_wdata = rkd_value;

    // Access sequencer: one outstanding request, responses outside REQ/WAIT ignored
    always_comb begin
        state_nxt = state;
        rdata_cap = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && in_is_mem) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_nxt = S_DONE;
                        rdata_cap = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_nxt = S_DONE;
                    rdata_cap = 1'b1;
                end
            end
            S_DONE: begin
                if (WB_allow_in) begin
                    state_nxt = (accept && in_is_mem) ? S_REQ : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            MEM_valid  <= 1'b0;
            mem_bundle <= '0;
            rdata_q    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (MEM_allow_in) begin
                MEM_valid <= EX_to_MEM_valid;
            end
            if (accept) begin
                mem_bundle <= to_MEM_data;
            end
            if (rdata_cap) begin
                rdata_q <= data_rdata;
            end
        end
    end

`ifdef MEM_FWD_EN
    // Bypass value is final_result; a load not yet in DONE forces a load-use stall
    assign MEM_fwd_valid = MEM_valid && gr_we && (dest != 5'd0);
    assign MEM_fwd_dest  = dest;
    assign MEM_fwd_stall = MEM_fwd_valid && res_from_mem && (state != S_DONE);
`endif

endmodule
